pipe_mdu_ctrl: RTL



---
 rtl/pipe_mdu_ctrl_pkg.sv | 34 +++
 rtl/pipe_mdu_ctrl_if.sv | 33 +++
 rtl/pipe_mdu_ctrl_md_iter_step.sv | 36 +++
 rtl/pipe_mdu_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/pipe_mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_mdu_ctrl_pkg
// Brief   : Shared op encodings, FSM states and constants for the MDU.
// Revision: 1.0 - initial release
// ============================================================================
package pipe_mdu_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  localparam int unsigned MD_ITER  = 32;
  localparam int unsigned MD_CNT_W = 6;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_mdu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_mdu_ctrl_if
// Brief   : EXE-stage request/response bundle between pipeline and MDU.
// Revision: 1.0 - initial release
// ============================================================================
interface pipe_mdu_ctrl_if;
  logic        estart;
  logic [1:0]  eop;
  logic [31:0] ea;
  logic [31:0] eb;
  logic        emfhi;
  logic        emflo;
  logic        emthi;
  logic        emtlo;
  logic        stall;
  logic        busy;
  logic [31:0] mdres;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;

  modport master (
    output estart, eop, ea, eb, emfhi, emflo, emthi, emtlo,
    input  stall, busy, mdres, hi, lo, div0
  );

  modport slave (
    input  estart, eop, ea, eb, emfhi, emflo, emthi, emtlo,
    output stall, busy, mdres, hi, lo, div0
  );
endinterface
`default_nettype wire

// File: rtl/pipe_mdu_ctrl_md_iter_step.sv
`default_nettype none
// ============================================================================
// Module  : md_iter_step
// Brief   : One combinational shift-add multiply / restoring divide step.
// Revision: 1.0 - initial release
// ============================================================================
module md_iter_step
  import pipe_mdu_ctrl_pkg::*;
(
  input  md_op_e      op,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);

  logic [32:0] w_sum;
  logic [32:0] w_rem;
  logic [32:0] w_diff;

  // acc = {partial product, remaining multiplier} or {remainder, dividend/quotient}
  always_comb begin
    w_sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    w_rem    = acc[63:31];
    w_diff   = w_rem - {1'b0, opnd};
    acc_next = {w_sum, acc[31:1]};
    if (md_is_div(op)) begin
      if (!w_diff[32]) begin
        acc_next = {w_diff[31:0], acc[30:0], 1'b1};
      end else begin
        acc_next = {w_rem[31:0], acc[30:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_mdu_ctrl
// Brief   : Iterative MULT/DIV sequencer owning HI/LO, with HI/LO interlock.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_mdu_ctrl
  import pipe_mdu_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            resetn,
  pipe_mdu_ctrl_if.slave  bus
);

  md_state_e          r_state;
  md_state_e          w_next_state;
  md_op_e             r_op;
  logic [63:0]        r_acc;
  logic [63:0]        w_acc_next;
  logic [31:0]        r_opnd;
  logic [31:0]        r_ea;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [MD_CNT_W-1:0] r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  md_op_e      w_op;
  logic        w_signed;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_div0;
  logic [63:0] w_prod;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;
  logic        w_busy;

  assign w_op     = md_op_e'(bus.eop);
  assign w_signed = md_is_signed(w_op);
  assign w_mag_a  = (w_signed && bus.ea[31]) ? -bus.ea : bus.ea;
  assign w_mag_b  = (w_signed && bus.eb[31]) ? -bus.eb : bus.eb;

  md_iter_step u_step (
    .op       (r_op),
    .acc      (r_acc),
    .opnd     (r_opnd),
    .acc_next (w_acc_next)
  );

  // Sign flags are only set for signed ops, so unsigned results pass straight through
  always_comb begin
    w_div0   = md_is_div(r_op) && (r_opnd == 32'd0);
    w_prod   = (r_sign_a != r_sign_b) ? -r_acc : r_acc;
    w_fix_hi = w_prod[63:32];
    w_fix_lo = w_prod[31:0];
    if (md_is_div(r_op)) begin
      w_fix_lo = (r_sign_a != r_sign_b) ? -r_acc[31:0] : r_acc[31:0];
      w_fix_hi = r_sign_a ? -r_acc[63:32] : r_acc[63:32];
      if (w_div0) begin
        w_fix_hi = r_ea;
        w_fix_lo = 32'hFFFF_FFFF;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (bus.estart) w_next_state = ST_CALC;
      ST_CALC: if (r_cnt == MD_CNT_W'(MD_ITER - 1)) w_next_state = ST_FIX;
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_op     <= MD_MULT;
      r_acc    <= 64'd0;
      r_opnd   <= 32'd0;
      r_ea     <= 32'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.estart) begin
            r_op     <= w_op;
            r_acc    <= {32'd0, w_mag_a};
            r_opnd   <= w_mag_b;
            r_ea     <= bus.ea;
            r_sign_a <= w_signed & bus.ea[31];
            r_sign_b <= w_signed & bus.eb[31];
            r_cnt    <= '0;
          end else begin
            if (bus.emthi) r_hi <= bus.ea;
            if (bus.emtlo) r_lo <= bus.ea;
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign w_busy    = (r_state != ST_IDLE);
  assign bus.busy  = w_busy;
  assign bus.stall = w_busy & (bus.estart | bus.emfhi | bus.emflo | bus.emthi | bus.emtlo);
  assign bus.mdres = bus.emfhi ? r_hi : r_lo;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
  assign bus.div0  = (r_state == ST_FIX) && w_div0;

endmodule
`default_nettype wire
